// File: rtl/ram_rr_arbiter_pkg.sv
// Shared types and constants for the round-robin RAM port arbiter.
package ram_arb_pkg;

    // Arbiter FSM: IDLE has no owner, LOCKED keeps the port for one burst.
    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // Width of the optional per-requester granted-beat counters.
    localparam int ARB_CNT_W = 16;

endpackage

// File: rtl/ram_rr_arbiter_rr_picker.sv
// Rotating-priority picker: one-hot grant to the first request at or above
// ptr, wrapping from NUM_REQ-1 back to 0. Purely combinational.
module rr_picker
    import ram_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt
);

    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    logic [NUM_REQ-1:0] upper_req;

    // Requests at or above the pointer take precedence over the wrapped ones.
    always_comb begin
        upper_req = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            upper_req[i] = req[i] && (i >= int'(ptr));
        end
    end

    // Isolate the lowest set bit of the chosen half (x & -x).
    assign gnt = (|upper_req) ? (upper_req & (~upper_req + ONE))
                              : (req & (~req + ONE));

endmodule

// File: rtl/ram_rr_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between NUM_REQ requesters.
// Bursts lock the port to their owner until the beat flagged last.
// Optional feature: define RAM_ARB_STATS_EN to add grant_cnt_o, a set of
// per-requester saturating granted-beat counters.
module ram_rr_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_WIDTH  = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int BYTE_WIDTH  = 8,
    parameter int BATCH_WIDTH = DATA_WIDTH / BYTE_WIDTH
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ-1:0]            last_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata_i,
    input  logic [NUM_REQ-1:0]            we_i,
    input  logic [NUM_REQ*BATCH_WIDTH-1:0] be_i,
    output logic [NUM_REQ-1:0]            gnt_o,
`ifdef RAM_ARB_STATS_EN
    output logic [NUM_REQ*ARB_CNT_W-1:0]  grant_cnt_o,
`endif
    output logic [NUM_REQ-1:0]            rvalid_o,
    output logic [DATA_WIDTH-1:0]         rdata_o,
    output logic [ADDR_WIDTH-1:0]         ram_addr_o,
    output logic [DATA_WIDTH-1:0]         ram_write_o,
    output logic                          ram_we_o,
    output logic [BATCH_WIDTH-1:0]        ram_be_o,
    input  logic [DATA_WIDTH-1:0]         ram_data_i
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    arb_state_e              state_reg;
    logic [IDX_W-1:0]        owner_reg;
    logic [IDX_W-1:0]        ptr_reg;
    logic [NUM_REQ-1:0]      rvalid_reg;
    logic [ADDR_WIDTH-1:0]   addr_hold_reg;
    logic [DATA_WIDTH-1:0]   wdata_hold_reg;

    logic [NUM_REQ-1:0]      pick_gnt;
    logic [NUM_REQ-1:0]      gnt_raw;
    logic [NUM_REQ-1:0]      gnt;
    logic                    any_gnt;
    logic [IDX_W-1:0]        win_idx;
    logic [IDX_W-1:0]        ptr_next;
    logic                    win_last;
    logic                    win_we;

    logic [ADDR_WIDTH-1:0]   addr_a  [NUM_REQ];
    logic [DATA_WIDTH-1:0]   wdata_a [NUM_REQ];
    logic [BATCH_WIDTH-1:0]  be_a    [NUM_REQ];

    // Split the packed per-requester buses into indexable arrays.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign addr_a[gi]  = addr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_a[gi] = wdata_i[gi*DATA_WIDTH +: DATA_WIDTH];
        assign be_a[gi]    = be_i[gi*BATCH_WIDTH +: BATCH_WIDTH];
    end

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req (req_i),
        .ptr (ptr_reg),
        .gnt (pick_gnt)
    );

    // Free arbitration when idle, otherwise only the owner may take a beat.
    always_comb begin
        if (state_reg == ARB_IDLE) begin
            gnt_raw = pick_gnt;
        end else begin
            gnt_raw = req_i & (ONE << owner_reg);
        end
    end

    // Nothing is granted while reset is held, so no write can slip through.
    assign gnt     = rst_n_i ? gnt_raw : '0;
    assign any_gnt = |gnt;

    // Encode the one-hot grant into the winner's index.
    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                win_idx = IDX_W'(i);
            end
        end
    end

    assign win_last = last_i[win_idx];
    assign win_we   = we_i[win_idx];
    assign ptr_next = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + IDX_W'(1);

    // Burst FSM, rotating pointer, read-return tracking and address hold.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg      <= ARB_IDLE;
            owner_reg      <= '0;
            ptr_reg        <= '0;
            rvalid_reg     <= '0;
            addr_hold_reg  <= '0;
            wdata_hold_reg <= '0;
        end else begin
            rvalid_reg <= (any_gnt && !win_we) ? gnt : '0;
            if (any_gnt) begin
                addr_hold_reg  <= addr_a[win_idx];
                wdata_hold_reg <= wdata_a[win_idx];
            end
            if (any_gnt && win_last) begin
                ptr_reg <= ptr_next;
            end
            case (state_reg)
                ARB_IDLE: begin
                    if (any_gnt && !win_last) begin
                        state_reg <= ARB_LOCKED;
                        owner_reg <= win_idx;
                    end
                end
                ARB_LOCKED: begin
                    if (any_gnt && win_last) begin
                        state_reg <= ARB_IDLE;
                    end
                end
                default: state_reg <= ARB_IDLE;
            endcase
        end
    end

    assign gnt_o       = gnt;
    assign ram_we_o    = any_gnt && win_we;
    assign ram_be_o    = any_gnt ? be_a[win_idx] : '0;
    assign ram_addr_o  = any_gnt ? addr_a[win_idx] : addr_hold_reg;
    assign ram_write_o = any_gnt ? wdata_a[win_idx] : wdata_hold_reg;
    assign rvalid_o    = rvalid_reg;
    // The RAM output is registered, so its data lines up with rvalid_reg.
    assign rdata_o     = (|rvalid_reg) ? ram_data_i : '0;

`ifdef RAM_ARB_STATS_EN
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cnt
        logic [ARB_CNT_W-1:0] cnt_reg;

        // Count granted beats, sticking at all-ones.
        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                cnt_reg <= '0;
            end else if (gnt[gi] && (cnt_reg != '1)) begin
                cnt_reg <= cnt_reg + ARB_CNT_W'(1);
            end
        end

        assign grant_cnt_o[gi*ARB_CNT_W +: ARB_CNT_W] = cnt_reg;
    end
`endif

endmodule

// File: tb/tb_ram_rr_arbiter.sv
// Self-checking bench for ram_rr_arbiter with a registered-read RAM model.
// Read returns are scoreboarded: expected data is queued at grant time and
// compared when rvalid_o is due one cycle later.
module tb_ram_rr_arbiter;

    localparam int N   = 4;
    localparam int AW  = 4;
    localparam int DW  = 32;
    localparam int BW  = 8;
    localparam int BTW = DW / BW;

    logic clk_i = 1'b0;
    logic rst_n_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic [N-1:0]     req_i, last_i, we_i;
    logic [N*AW-1:0]  addr_i;
    logic [N*DW-1:0]  wdata_i;
    logic [N*BTW-1:0] be_i;
    logic [N-1:0]     gnt_o, rvalid_o;
    logic [DW-1:0]    rdata_o, ram_write_o;
    logic [AW-1:0]    ram_addr_o;
    logic             ram_we_o;
    logic [BTW-1:0]   ram_be_o;
    logic [DW-1:0]    ram_data_i = '0;
`ifdef RAM_ARB_STATS_EN
    logic [N*16-1:0]  grant_cnt_o;
`endif

    logic [AW-1:0]  r_addr  [N];
    logic [DW-1:0]  r_wdata [N];
    logic [BTW-1:0] r_be    [N];

    always_comb begin
        addr_i  = '0;
        wdata_i = '0;
        be_i    = '0;
        for (int i = 0; i < N; i++) begin
            addr_i[i*AW +: AW]    = r_addr[i];
            wdata_i[i*DW +: DW]   = r_wdata[i];
            be_i[i*BTW +: BTW]    = r_be[i];
        end
    end

    ram_rr_arbiter #(
        .NUM_REQ    (N),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .BYTE_WIDTH (BW)
    ) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .req_i       (req_i),
        .last_i      (last_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .we_i        (we_i),
        .be_i        (be_i),
        .gnt_o       (gnt_o),
`ifdef RAM_ARB_STATS_EN
        .grant_cnt_o (grant_cnt_o),
`endif
        .rvalid_o    (rvalid_o),
        .rdata_o     (rdata_o),
        .ram_addr_o  (ram_addr_o),
        .ram_write_o (ram_write_o),
        .ram_we_o    (ram_we_o),
        .ram_be_o    (ram_be_o),
        .ram_data_i  (ram_data_i)
    );

    // Single-port RAM with byte enables and a registered read.
    logic [DW-1:0] mem [16] = '{default: '0};
    always @(posedge clk_i) begin
        if (ram_we_o) begin
            for (int b = 0; b < BTW; b++) begin
                if (ram_be_o[b]) mem[ram_addr_o][b*BW +: BW] <= ram_write_o[b*BW +: BW];
            end
        end
        ram_data_i <= mem[ram_addr_o];
    end

    // Bench-side expected memory contents, updated from the stimulus.
    logic [DW-1:0] shadow [16] = '{default: '0};

    typedef struct {
        int            cyc;
        int            idx;
        logic [DW-1:0] data;
    } rd_t;
    rd_t sb_q[$];

    int            n_checks  = 0;
    int            n_errors  = 0;
    int            cyc       = 0;
    logic [AW-1:0] last_addr = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic rq, input logic lst, input logic we,
                           input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BTW-1:0] be);
        req_i[i]   = rq;
        last_i[i]  = lst;
        we_i[i]    = we;
        r_addr[i]  = a;
        r_wdata[i] = d;
        r_be[i]    = be;
    endtask

    task automatic clear_all();
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    // One clock of checking: read return due this cycle, grant, RAM side.
    task automatic step(input string tag, input logic [N-1:0] exp_gnt);
        rd_t           e;
        logic [N-1:0]  exp_rv;
        logic [DW-1:0] nd;
        int            w;
        @(negedge clk_i);
        if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
            e = sb_q.pop_front();
            exp_rv = '0;
            exp_rv[e.idx] = 1'b1;
            chk({tag, "/rvalid"}, 64'(rvalid_o), 64'(exp_rv));
            chk({tag, "/rdata"}, 64'(rdata_o), 64'(e.data));
        end else begin
            chk({tag, "/rvalid"}, 64'(rvalid_o), 64'(0));
        end
        chk({tag, "/gnt"}, 64'(gnt_o), 64'(exp_gnt));
        w = -1;
        for (int i = 0; i < N; i++) if (exp_gnt[i]) w = i;
        if (w >= 0) begin
            chk({tag, "/ram_we"}, 64'(ram_we_o), 64'(we_i[w]));
            chk({tag, "/ram_addr"}, 64'(ram_addr_o), 64'(r_addr[w]));
            chk({tag, "/ram_be"}, 64'(ram_be_o), 64'(r_be[w]));
            if (we_i[w]) begin
                chk({tag, "/ram_wdata"}, 64'(ram_write_o), 64'(r_wdata[w]));
                nd = shadow[r_addr[w]];
                for (int b = 0; b < BTW; b++) begin
                    if (r_be[w][b]) nd[b*BW +: BW] = r_wdata[w][b*BW +: BW];
                end
                shadow[r_addr[w]] = nd;
            end else begin
                sb_q.push_back('{cyc + 1, w, shadow[r_addr[w]]});
            end
            last_addr = r_addr[w];
        end else begin
            chk({tag, "/ram_we_idle"}, 64'(ram_we_o), 64'(0));
            chk({tag, "/ram_be_idle"}, 64'(ram_be_o), 64'(0));
            chk({tag, "/ram_addr_hold"}, 64'(ram_addr_o), 64'(last_addr));
        end
        $display("cyc %0d %s: req=%b gnt=%b rvalid=%b rdata=%h", cyc, tag, req_i, gnt_o, rvalid_o, rdata_o);
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "/gnt"}, 64'(gnt_o), 64'(0));
        chk({tag, "/rvalid"}, 64'(rvalid_o), 64'(0));
        chk({tag, "/rdata"}, 64'(rdata_o), 64'(0));
        chk({tag, "/ram_we"}, 64'(ram_we_o), 64'(0));
        chk({tag, "/ram_be"}, 64'(ram_be_o), 64'(0));
        chk({tag, "/ram_addr"}, 64'(ram_addr_o), 64'(0));
        chk({tag, "/ram_wdata"}, 64'(ram_write_o), 64'(0));
    endtask

    initial begin
        clear_all();
        // Reset with a pending request: nothing may be granted.
        set_req(0, 1'b1, 1'b1, 1'b1, 4'd3, 32'h1111_1111, 4'hF);
        repeat (2) @(posedge clk_i);
        #1;
        check_reset_outputs("reset");
        clear_all();
        rst_n_i = 1'b1;
        step("idle", 4'b0000);

        // Round robin across four single-beat reads.
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b1, 1'b0, AW'(i), '0, '0);
        step("rr0", 4'b0001);
        step("rr1", 4'b0010);
        step("rr2", 4'b0100);
        step("rr3", 4'b1000);
        step("rr4", 4'b0001);
        clear_all();
        step("rr_drain", 4'b0000);

        // Requester 2 holds a 4-beat burst while requester 0 waits.
        set_req(0, 1'b1, 1'b1, 1'b0, 4'd3, '0, '0);
        for (int b = 0; b < 4; b++) begin
            set_req(2, 1'b1, (b == 3), 1'b0, AW'(4 + b), '0, '0);
            step("burst2", 4'b0100);
        end
        set_req(2, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        step("handover0", 4'b0001);
        clear_all();
        step("burst_drain", 4'b0000);

        // Owner 1 pauses mid-burst while requester 3 keeps asking.
        set_req(3, 1'b1, 1'b1, 1'b0, 4'd2, '0, '0);
        set_req(1, 1'b1, 1'b0, 1'b1, 4'd10, 32'hA5A5_0001, 4'hF);
        step("own1_b0", 4'b0010);
        set_req(1, 1'b0, 1'b0, 1'b1, 4'd10, 32'hA5A5_0001, 4'hF);
        repeat (3) step("own1_drop", 4'b0000);
        set_req(1, 1'b1, 1'b1, 1'b1, 4'd11, 32'h5A5A_0002, 4'hF);
        step("own1_last", 4'b0010);
        set_req(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        step("req3_after", 4'b1000);
        clear_all();
        step("lock_drain", 4'b0000);

        // Write then read back, including a single-byte update.
        set_req(0, 1'b1, 1'b1, 1'b1, 4'd5, 32'hDEAD_BEEF, 4'hF);
        step("wr5", 4'b0001);
        set_req(0, 1'b1, 1'b1, 1'b0, 4'd5, '0, '0);
        step("rd5", 4'b0001);
        set_req(0, 1'b1, 1'b1, 1'b1, 4'd5, 32'h0000_5500, 4'b0010);
        step("wr5_be", 4'b0001);
        set_req(0, 1'b1, 1'b1, 1'b0, 4'd5, '0, '0);
        step("rd5_be", 4'b0001);
        clear_all();
        set_req(1, 1'b1, 1'b1, 1'b0, 4'd10, '0, '0);
        step("rd10", 4'b0010);
        clear_all();
        step("rw_drain", 4'b0000);

        // Reset in the middle of a locked write burst.
        set_req(2, 1'b1, 1'b0, 1'b1, 4'd8, 32'hCAFE_F00D, 4'hF);
        step("lock_wr", 4'b0100);
        set_req(2, 1'b1, 1'b0, 1'b1, 4'd9, 32'h1234_5678, 4'hF);
        rst_n_i = 1'b0;
        #2;
        check_reset_outputs("mid_reset");
        sb_q.delete();
        @(posedge clk_i);
        #1;
        rst_n_i   = 1'b1;
        last_addr = '0;
        cyc++;
        set_req(0, 1'b1, 1'b1, 1'b0, 4'd9, '0, '0);
        set_req(1, 1'b1, 1'b1, 1'b0, 4'd8, '0, '0);
        set_req(2, 1'b1, 1'b1, 1'b0, 4'd5, '0, '0);
        set_req(3, 1'b1, 1'b1, 1'b0, 4'd11, '0, '0);
        step("post_rst0", 4'b0001);
        step("post_rst1", 4'b0010);
        step("post_rst2", 4'b0100);
        step("post_rst3", 4'b1000);
        clear_all();
        step("post_rst_drain", 4'b0000);

`ifdef RAM_ARB_STATS_EN
        // Saturation of requester 1's counter with no-byte-enable writes.
        set_req(1, 1'b1, 1'b1, 1'b1, 4'd0, '0, 4'h0);
        repeat (32'h10005) @(posedge clk_i);
        #1;
        clear_all();
        @(negedge clk_i);
        chk("cnt1_sat", 64'(grant_cnt_o[16 +: 16]), 64'h FFFF);
        chk("cnt0", 64'(grant_cnt_o[0 +: 16]), 64'd1);
        $display("stats: grant_cnt_o=%h", grant_cnt_o);
`endif

        chk("sb_empty", 64'(sb_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ram_rr_arbiter.md
RAM_RR_ARBITER -- requirements
Module: ram_rr_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4: number of requesters sharing one RAM port, range 2..8.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 4: RAM word-address width.
REQ-003 The block SHALL have parameter DATA_WIDTH, default 32: RAM word width.
REQ-004 The block SHALL have parameter BYTE_WIDTH, default 8: byte-enable granule; BATCH_WIDTH = DATA_WIDTH/BYTE_WIDTH.
REQ-005 The block SHALL have port clk_i, input, 1 bit: clock; rst_n_i, input, 1 bit: reset, asynchronous, active-low; clock clk_i.
REQ-006 The block SHALL have port req_i, input, NUM_REQ bits: per-requester beat request.
REQ-007 The block SHALL have port last_i, input, NUM_REQ bits: the requested beat ends that requester's burst.
REQ-008 The block SHALL have ports addr_i (NUM_REQ*ADDR_WIDTH), wdata_i (NUM_REQ*DATA_WIDTH), we_i (NUM_REQ), be_i (NUM_REQ*BATCH_WIDTH), all inputs: packed per-requester beat fields, with requester 0 in the LSBs.
REQ-009 The block SHALL have port gnt_o, output, NUM_REQ bits: one-hot beat acceptance.
REQ-010 The block SHALL have ports rvalid_o (output, NUM_REQ bits) and rdata_o (output, DATA_WIDTH bits): read return, shared data bus.
REQ-011 The block SHALL have RAM-side outputs ram_addr_o (ADDR_WIDTH), ram_write_o (DATA_WIDTH), ram_we_o (1), ram_be_o (BATCH_WIDTH), and RAM-side input ram_data_i (DATA_WIDTH, registered RAM output, 1-cycle read latency).

Function
REQ-012 The block SHALL implement two states: IDLE (no owner) and LOCKED (owner holds the port until its last beat).
REQ-013 In IDLE, the block SHALL grant the first asserted req_i at or after the rotating pointer ptr, searching upward with wrap NUM_REQ-1 -> 0, combinationally in the same cycle.
REQ-014 A granted beat SHALL drive ram_addr_o/ram_write_o/ram_be_o from the winner's fields and ram_we_o = we_i[winner] in the same cycle.
REQ-015 When there is no grant, the block SHALL drive ram_we_o=0 and ram_be_o=0, and SHALL hold ram_addr_o at the last granted address.
REQ-016 An IDLE grant with last_i=0 SHALL move the FSM to LOCKED with owner=winner; with last_i=1 the FSM SHALL stay in IDLE.
REQ-017 In LOCKED, the block SHALL grant only the owner, and only when req_i[owner]=1; requests from other requesters SHALL be ignored.
REQ-018 If the owner deasserts req_i mid-burst, the FSM SHALL stay LOCKED with no grant and no RAM write.
REQ-019 An owner beat with last_i=1 SHALL return the FSM to IDLE on the next cycle.
REQ-020 ptr SHALL update to (requester+1) mod NUM_REQ on every grant carrying last_i=1.
REQ-021 For a granted read (we_i=0), the block SHALL assert rvalid_o[requester] exactly one cycle later, with rdata_o = ram_data_i; all other rvalid_o bits SHALL be 0.
REQ-022 Granted writes SHALL produce no rvalid_o.
REQ-023 The block SHALL sustain back-to-back beats at one grant per cycle, including a hand-over from one requester to another in the cycle after a last beat.

Reset
REQ-024 On reset, the block SHALL set FSM=IDLE, ptr=0, owner=0, gnt_o=0, rvalid_o=0, rdata_o=0, ram_we_o=0, ram_be_o=0, ram_addr_o=0, ram_write_o=0.
REQ-025 On reset asserted mid-burst, the block SHALL abandon the lock and drop any pending rvalid_o, and SHALL not complete the write.

Configuration
REQ-026 When macro RAM_ARB_STATS_EN is defined, the block SHALL add output grant_cnt_o (NUM_REQ*16 bits): per-requester saturating 16-bit granted-beat counters, reset to 0, saturating at 0xFFFF.
REQ-027 When RAM_ARB_STATS_EN is undefined, the port and counters SHALL be absent, and arbitration behaviour SHALL be identical.

Structure
REQ-028 Package ram_arb_pkg SHALL hold the FSM state enum (ARB_IDLE, ARB_LOCKED) and the counter width constant ARB_CNT_W=16.
REQ-029 The rotating-priority search SHALL be implemented as a combinational sub-module, rr_picker (inputs req vector and ptr; output one-hot grant).

Verification
REQ-030 The bench SHALL cover: after reset, req_i=4'b1111, all last_i=1, all reads -> grants in order 0,1,2,3,0; rvalid_o one cycle after each grant.
REQ-031 The bench SHALL cover: req 2 bursts 4 beats (last on beat 4) while req 0 requests -> gnt_o=4'b0100 for 4 granted cycles, then req 0 granted the next cycle.
REQ-032 The bench SHALL cover: owner 1 drops req_i for 3 cycles mid-burst while req 3 requests -> no grant and ram_we_o=0 for those cycles, and the lock is kept.
REQ-033 The bench SHALL cover: req 0 write addr 5, data 0xDEADBEEF, be 4'hF, then read addr 5 -> rvalid_o[0] with rdata_o=0xDEADBEEF.
REQ-034 The bench SHALL cover: rst_n_i pulsed low during a LOCKED write burst -> all outputs at reset values, ptr=0, next grant to requester 0.
REQ-035 The bench SHALL cover: with RAM_ARB_STATS_EN defined, 0x10005 single beats from requester 1 -> grant_cnt_o[1]=0xFFFF.
